// File: rtl/fp32_to_bcd_seq.sv
// Sequential IEEE-754 single to signed BCD converter (INT_DIGITS.FRAC_DIGITS) with start/ready/done handshake.
// Define FP2BCD_ROUND_EN to add a guard digit and round-half-up instead of truncating the fraction.
module fp32_to_bcd_seq #(
  parameter int INT_DIGITS  = 4,
  parameter int FRAC_DIGITS = 6
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic [31:0]              in,
  output logic                     ready,
  output logic                     done,
  output logic                     sign,
  output logic [4*INT_DIGITS-1:0]  int_bcd,
  output logic [4*FRAC_DIGITS-1:0] frac_bcd,
  output logic                     ovf,
  output logic                     nan,
  output logic                     inf,
  output logic                     zero
);

`ifdef FP2BCD_ROUND_EN
  localparam int NF = FRAC_DIGITS + 1;
  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_INT, S_FRAC, S_ROUND, S_DONE} state_t;
`else
  localparam int NF = FRAC_DIGITS;
  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_INT, S_FRAC, S_DONE} state_t;
`endif
  localparam int IW = 4*INT_DIGITS;
  localparam int FW = 4*FRAC_DIGITS;

  state_t state, state_nx;

  logic [31:0]     op;
  logic [31:0]     dd;
  logic [23:0]     bin;
  logic [31:0]     fr;
  logic [4*NF-1:0] fdig;
  logic [4:0]      cnt;
  logic            sp_nan, sp_inf, sp_zero, sp_ovf;
  logic            rnd_ovf;

  logic [7:0]      ex;
  logic [22:0]     fm;
  logic [23:0]     mant;
  logic            is_nan, is_inf, is_zero, is_big, special;
  logic [55:0]     x;
  logic [31:0]     dd_adj;
  logic [35:0]     p;
  logic [4*NF+3:0] fsh;
  logic            int_hi;

  always_comb begin
    ex      = op[30:23];
    fm      = op[22:0];
    mant    = {1'b1, fm};
    is_nan  = (ex == 8'hFF) && (fm != 23'd0);
    is_inf  = (ex == 8'hFF) && (fm == 23'd0);
    is_zero = (ex == 8'd0);
    is_big  = (ex >= 8'd151) && (ex != 8'hFF);
    special = is_nan || is_inf || is_zero || is_big;
    // Q24.32 alignment: binary point sits between x[32] and x[31].
    if (ex >= 8'd118) x = {32'd0, mant} << (ex - 8'd118);
    else              x = {32'd0, mant} >> (8'd118 - ex);
  end

  always_comb begin
    dd_adj = dd;
    for (int i = 0; i < 8; i++) begin
      if (dd[4*i +: 4] >= 4'd5) dd_adj[4*i +: 4] = dd[4*i +: 4] + 4'd3;
    end
  end

  assign p      = ({4'd0, fr} << 3) + ({4'd0, fr} << 1);
  assign fsh    = {fdig, p[35:32]};
  assign int_hi = |dd[31:IW];

`ifdef FP2BCD_ROUND_EN
  logic [IW+FW-1:0] rchain;
  logic             rcarry;
  logic [4:0]       rsum;

  always_comb begin
    rchain = {dd[IW-1:0], fdig[4*NF-1:4]};
    rcarry = (fdig[3:0] >= 4'd5);
    rsum   = 5'd0;
    for (int i = 0; i < INT_DIGITS + FRAC_DIGITS; i++) begin
      rsum = {1'b0, rchain[4*i +: 4]} + {4'd0, rcarry};
      if (rsum >= 5'd10) begin
        rchain[4*i +: 4] = 4'd0;
        rcarry           = 1'b1;
      end else begin
        rchain[4*i +: 4] = rsum[3:0];
        rcarry           = 1'b0;
      end
    end
  end
`endif

  assign ready = (state == S_IDLE) && !done;

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start && ready) state_nx = S_UNPACK;
      S_UNPACK: state_nx = special ? S_DONE : S_INT;
      S_INT:    if (cnt == 5'd22) state_nx = S_FRAC;
`ifdef FP2BCD_ROUND_EN
      S_FRAC:   if (cnt == 5'(NF-1)) state_nx = S_ROUND;
      S_ROUND:  state_nx = S_DONE;
`else
      S_FRAC:   if (cnt == 5'(NF-1)) state_nx = S_DONE;
`endif
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op       <= 32'd0;
      dd       <= 32'd0;
      bin      <= 24'd0;
      fr       <= 32'd0;
      fdig     <= '0;
      cnt      <= 5'd0;
      sp_nan   <= 1'b0;
      sp_inf   <= 1'b0;
      sp_zero  <= 1'b0;
      sp_ovf   <= 1'b0;
      rnd_ovf  <= 1'b0;
      done     <= 1'b0;
      sign     <= 1'b0;
      int_bcd  <= '0;
      frac_bcd <= '0;
      ovf      <= 1'b0;
      nan      <= 1'b0;
      inf      <= 1'b0;
      zero     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && ready) op <= in;
        end
        S_UNPACK: begin
          sp_nan  <= is_nan;
          sp_inf  <= is_inf;
          sp_zero <= is_zero;
          sp_ovf  <= is_big;
          rnd_ovf <= 1'b0;
          cnt     <= 5'd0;
          fdig    <= '0;
          if (special) begin
            dd  <= 32'd0;
            bin <= 24'd0;
            fr  <= 32'd0;
          end else begin
            // First double-dabble step needs no add-3 since all digits start at zero.
            dd  <= {31'd0, x[55]};
            bin <= {x[54:32], 1'b0};
            fr  <= x[31:0];
          end
        end
        S_INT: begin
          dd  <= {dd_adj[30:0], bin[23]};
          bin <= {bin[22:0], 1'b0};
          cnt <= (cnt == 5'd22) ? 5'd0 : cnt + 5'd1;
        end
        S_FRAC: begin
          fdig <= fsh[4*NF-1:0];
          fr   <= p[31:0];
          cnt  <= cnt + 5'd1;
        end
`ifdef FP2BCD_ROUND_EN
        S_ROUND: begin
          dd[IW-1:0]     <= rchain[IW+FW-1:FW];
          fdig[4*NF-1:4] <= rchain[FW-1:0];
          rnd_ovf        <= rcarry;
        end
`endif
        S_DONE: begin
          done     <= 1'b1;
          sign     <= op[31] && !sp_nan;
          int_bcd  <= dd[IW-1:0];
          frac_bcd <= fdig[4*NF-1 -: FW];
          ovf      <= sp_ovf || int_hi || rnd_ovf;
          nan      <= sp_nan;
          inf      <= sp_inf;
          zero     <= sp_zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_to_bcd_seq.sv
// Directed bench for fp32_to_bcd_seq at default digit counts; expectations follow FP2BCD_ROUND_EN.
module tb_fp32_to_bcd_seq;
  localparam int ID = 4;
  localparam int FD = 6;
`ifdef FP2BCD_ROUND_EN
  localparam int LN = 27 + FD;
  localparam logic [31:0] F162  = 32'h200001;
  localparam logic [31:0] I3F   = 32'h0003;
  localparam logic [31:0] F3F   = 32'h000000;
`else
  localparam int LN = 25 + FD;
  localparam logic [31:0] F162  = 32'h200000;
  localparam logic [31:0] I3F   = 32'h0002;
  localparam logic [31:0] F3F   = 32'h999999;
`endif

  logic            CLK = 1'b0;
  logic            RST;
  logic            start;
  logic [31:0]     din;
  logic            ready, done, sign, ovf, nan, inf, zero;
  logic [4*ID-1:0] int_bcd;
  logic [4*FD-1:0] frac_bcd;

  int total = 0;
  int bad   = 0;

  fp32_to_bcd_seq #(.INT_DIGITS(ID), .FRAC_DIGITS(FD)) dut (
    .CLK(CLK), .RST(RST), .start(start), .in(din),
    .ready(ready), .done(done), .sign(sign),
    .int_bcd(int_bcd), .frac_bcd(frac_bcd),
    .ovf(ovf), .nan(nan), .inf(inf), .zero(zero)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  task automatic convert(input logic [31:0] val, output int lat);
    int guard;
    guard = 0;
    while (!ready && guard < 200) begin
      @(posedge CLK); #1;
      guard++;
    end
    chk("ready_before_start", 32'(ready), 32'd1);
    start = 1'b1;
    din   = val;
    @(posedge CLK); #1;
    start = 1'b0;
    lat = 0;
    do begin
      @(posedge CLK); #1;
      lat++;
    end while (!done && lat < 100);
  endtask

  task automatic expect_res(input string tag, input int lat, input int want_lat,
                            input logic [31:0] want_int, input logic [31:0] want_frac,
                            input logic want_sign, input logic [3:0] want_flags);
    chk({tag, "_lat"},   32'(lat),      32'(want_lat));
    chk({tag, "_int"},   32'(int_bcd),  want_int);
    chk({tag, "_frac"},  32'(frac_bcd), want_frac);
    chk({tag, "_sign"},  32'(sign),     32'(want_sign));
    chk({tag, "_flags"}, 32'({ovf, nan, inf, zero}), 32'(want_flags));
  endtask

  initial begin
    int  lat;
    bit  saw_done;
    RST   = 1'b1;
    start = 1'b0;
    din   = 32'd0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_outs",  32'({sign, ovf, nan, inf, zero}), 32'd0);
    chk("rst_int",   32'(int_bcd),  32'd0);
    chk("rst_frac",  32'(frac_bcd), 32'd0);
    RST = 1'b0;

    convert(32'h4181999A, lat);
    expect_res("v16p2", lat, LN, 32'h0016, F162, 1'b0, 4'b0000);
    @(posedge CLK); #1;
    chk("done_pulse_width", 32'(done),  32'd0);
    chk("ready_after_done", 32'(ready), 32'd1);
    repeat (3) @(posedge CLK);
    #1;
    chk("hold_int",  32'(int_bcd),  32'h0016);
    chk("hold_frac", 32'(frac_bcd), F162);

    convert(32'h403FFFFF, lat);
    expect_res("trunc", lat, LN, I3F, F3F, 1'b0, 4'b0000);

    convert(32'h4640E400, lat);
    expect_res("v12345", lat, LN, 32'h2345, 32'h0, 1'b0, 4'b1000);

    convert(32'h4B800000, lat);
    expect_res("two24", lat, 2, 32'h0, 32'h0, 1'b0, 4'b1000);

    convert(32'h7FC00000, lat);
    expect_res("qnan", lat, 2, 32'h0, 32'h0, 1'b0, 4'b0100);

    convert(32'hFF800000, lat);
    expect_res("ninf", lat, 2, 32'h0, 32'h0, 1'b1, 4'b0010);

    convert(32'h80000000, lat);
    expect_res("nzero", lat, 2, 32'h0, 32'h0, 1'b1, 4'b0001);

    // Second start while busy must not disturb the conversion in flight.
    @(posedge CLK); #1;
    start = 1'b1;
    din   = 32'h4181999A;
    @(posedge CLK); #1;
    start = 1'b0;
    lat = 0;
    do begin
      @(posedge CLK); #1;
      lat++;
      if (lat == 5) begin
        start = 1'b1;
        din   = 32'h7FC00000;
      end else begin
        start = 1'b0;
      end
    end while (!done && lat < 100);
    start = 1'b0;
    expect_res("busy_start", lat, LN, 32'h0016, F162, 1'b0, 4'b0000);
    @(posedge CLK); #1;
    chk("busy_no_second_done", 32'(done), 32'd0);

    // Reset sampled on the 10th edge after acceptance.
    @(posedge CLK); #1;
    start = 1'b1;
    din   = 32'h403FFFFF;
    @(posedge CLK); #1;
    start = 1'b0;
    saw_done = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) RST = 1'b1;
      @(posedge CLK); #1;
      if (done) saw_done = 1'b1;
    end
    RST = 1'b0;
    chk("rst_mid_ready", 32'(ready), 32'd1);
    chk("rst_mid_outs",  32'({done, sign, ovf, nan, inf, zero}), 32'd0);
    chk("rst_mid_int",   32'(int_bcd),  32'd0);
    chk("rst_mid_frac",  32'(frac_bcd), 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK); #1;
      if (done) saw_done = 1'b1;
    end
    chk("rst_mid_no_done", 32'(saw_done), 32'd0);

    convert(32'h3DCCCCCD, lat);
    expect_res("b2b_first", lat, LN, 32'h0, 32'h100000, 1'b0, 4'b0000);
    convert(32'hC1200000, lat);
    expect_res("b2b_second", lat, LN, 32'h0010, 32'h0, 1'b1, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp32_to_bcd_seq.md
# fp32_to_bcd_seq

Parametrised sequential converter from an IEEE-754 single-precision value to signed fixed-format decimal. It produces INT_DIGITS BCD integer digits and FRAC_DIGITS BCD fraction digits, plus special-case and overflow flags. Requests use a start/ready/done handshake. It is the next generation of the float-to-decimal path in the calculator and sits between the FP result register and the display/export stage.

## Interface
- INT_DIGITS, 4: BCD integer digits output; legal range 1..7.
- FRAC_DIGITS, 6: BCD fraction digits output; legal range 1..9.
- CLK  in  1  clock; all state updates on its rising edge.
- RST  in  1  reset; synchronous and active-high.
- start  in  1  request strobe; sampled only while ready=1.
- in  in  32  IEEE-754 single operand; captured on the edge that accepts start.
- ready  out  1  high in IDLE only.
- done  out  1  one-cycle pulse; result outputs are valid from this pulse onward.
- sign  out  1  in[31]; forced to 0 for NaN.
- int_bcd  out  4*INT_DIGITS  integer digits, most significant digit at the MSBs.
- frac_bcd  out  4*FRAC_DIGITS  fraction digits; the first digit after the point is at the MSBs.
- ovf, nan, inf, zero  out  1 each  status flags.

## Operation
- States: IDLE, UNPACK, INT, FRAC, ROUND (present only with the configuration macro), DONE.
- IDLE: ready=1. If start=1, capture in and go to UNPACK.
- UNPACK:
  - Split the operand: e = exp-127, mant = {1, frac23}.
  - exp=255, frac≠0: nan=1.
  - exp=255, frac=0: inf=1.
  - exp=0: zero=1; denormals are flushed to zero.
  - e≥24: ovf=1.
  - Each of these four cases goes to DONE with all digits 0.
  - Otherwise build the 56-bit Q24.32 value X = mant<<(e+9) when e+9≥0, else mant>>(-(e+9)), truncating. Go to INT.
- INT: 24 double-dabble iterations on X[55:32], giving 8 BCD digits.
  - At the end, ovf=1 if any digit above INT_DIGITS is nonzero.
  - Go to FRAC in both cases; the fraction is still computed.
- FRAC: FRAC_DIGITS iterations on F = X[31:0].
  - Each iteration computes P = (F<<3)+(F<<1) as 36 bits.
  - The next digit is P[35:32]; F takes P[31:0].
  - Fraction digits are truncated, not rounded.
- DONE: register all outputs, pulse done, return to IDLE.
- Outputs hold their values until the next DONE. The flags of a new result replace the old ones; they are not accumulated.
- start while ready=0 is ignored, with no queueing.
- RST at any time, including mid-conversion: state goes to IDLE and the conversion is abandoned.

## Timing
- Reset values: ready=1, done=0, sign=0, int_bcd=0, frac_bcd=0, ovf=0, nan=0, inf=0, zero=0.
- Latency L counts rising edges from the start-accepting edge to the edge at which done rises.
- Normal path: L = 25+FRAC_DIGITS (31 at defaults).
- Special or e≥24 path: L = 2.
- With rounding enabled, the normal path is L = 27+FRAC_DIGITS.
- done is high for exactly one cycle. ready rises in the same cycle that done falls.
- Back-to-back operation: start may be asserted in the cycle after done and is accepted on that edge.

## Configuration
- FP2BCD_ROUND_EN defined:
  - FRAC runs one extra iteration to produce a guard digit.
  - ROUND then adds 1 to the frac_bcd‖int_bcd chain if the guard digit is ≥5 (round half up), rippling the decimal carry within one cycle.
  - A carry out of the integer MSD sets ovf=1.
- FP2BCD_ROUND_EN undefined: fraction digits are truncated, the ROUND state does not exist, and no guard digit is computed.

## Test plan
- 0x4181999A (16.2) at defaults → int_bcd=0x0016, frac_bcd=0x200000, sign=0, all flags 0, done at L=31.
- 0x403FFFFF → truncation build: int_bcd=0x0002, frac_bcd=0x999999. With FP2BCD_ROUND_EN: int_bcd=0x0003, frac_bcd=0x000000, L=33.
- 0x4640E400 (12345.0) with INT_DIGITS=4 → ovf=1. 0x4B800000 (2^24) → ovf=1 at L=2.
- 0x7FC00000 → nan=1, sign=0. 0xFF800000 → inf=1, sign=1. 0x80000000 → zero=1, sign=1. All three at L=2 with digits 0.
- Pulse start again mid-conversion → ignored, result unchanged. Assert RST at cycle 10 of a conversion → no done, all outputs at reset values, ready=1 on the next cycle.
- Back-to-back: 0x3DCCCCCD then 0xC1200000 → first result 0.100000; second result sign=1, int_bcd=0x0010, frac_bcd=0.
